cgra_xy_router: RTL and testbench

- Parametrised successor of the fixed 4x4 edge router for the CGRA mapping flow.
- Routes one DFG edge at a time (src PE to dst PE) over a GRID_W x GRID_H mesh. Routing is greedy XY: X first, falling back to Y when X is blocked.
- Tracks per-PE link occupancy and bypass count, and rips up a partial path on failure.
- Edges arrive over a valid/ready stream instead of file load. Per-edge results leave on a second stream. Sits between the edge scheduler and the configuration writer.

---
 rtl/cgra_route_pkg.sv | 51 +++++
 rtl/cgra_node_table.sv | 57 +++++
 rtl/cgra_xy_router_chk.sv | 22 ++
 rtl/cgra_xy_router.sv | 220 ++++++++++++++++++++++
 tb/tb_cgra_xy_router.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cgra_route_pkg.sv
// Shared types and mesh index helpers for the CGRA XY edge router.
package cgra_route_pkg;

  localparam int BYP_W  = 4;   // storage width of a node bypass counter
  localparam int NODE_W = 16;  // storage width of a node index on the path stack

  typedef enum logic [1:0] {
    DIR_BOT   = 2'd0,
    DIR_TOP   = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_CHECK  = 3'd2,
    S_EVAL   = 3'd3,
    S_UNWIND = 3'd4,
    S_RESP   = 3'd5
  } state_e;

  typedef struct packed {
    logic [3:0]       links;
    logic [BYP_W-1:0] byp;
  } node_t;

  typedef struct packed {
    logic [NODE_W-1:0] node;
    dir_e              dir;
  } stack_entry_t;

  function automatic int idx2x(input int idx, input int grid_w);
    return idx % grid_w;
  endfunction

  function automatic int idx2y(input int idx, input int grid_w);
    return idx / grid_w;
  endfunction

  function automatic int neighbour(input int idx, input dir_e d, input int grid_w);
    case (d)
      DIR_RIGHT: return idx + 1;
      DIR_LEFT:  return idx - 1;
      DIR_TOP:   return idx - grid_w;
      DIR_BOT:   return idx + grid_w;
      default:   return idx;
    endcase
  endfunction

endpackage

// File: rtl/cgra_node_table.sv
// Per-PE link/bypass table: one write port, clear-all and two combinational read ports.
module cgra_node_table
  import cgra_route_pkg::*;
#(
  parameter int NODES = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_all,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  dir_e          wr_dir,
  input  logic          wr_set,
  input  logic          byp_inc,
  input  logic          byp_dec,
  input  logic [AW-1:0] eval_addr,
  output node_t         eval_node,
  input  logic [AW-1:0] insp_addr,
  output node_t         insp_node
);

  node_t nodes_r [NODES];
  logic  wr_in_range_s;
  logic  eval_in_range_s;
  logic  insp_in_range_s;

  // address range qualification (NODES need not be a power of two)
  always_comb begin
    wr_in_range_s   = ({1'b0, wr_addr}   < (AW+1)'(NODES));
    eval_in_range_s = ({1'b0, eval_addr} < (AW+1)'(NODES));
    insp_in_range_s = ({1'b0, insp_addr} < (AW+1)'(NODES));
  end

  // table update: reset/clear-all wins over the single write port
  always_ff @(posedge clk) begin
    if (reset || clr_all) begin
      for (int i = 0; i < NODES; i++) nodes_r[i] <= '0;
    end else if (wr_en && wr_in_range_s) begin
      nodes_r[wr_addr].links[wr_dir] <= wr_set;
      if (byp_inc) begin
        nodes_r[wr_addr].byp <= nodes_r[wr_addr].byp + BYP_W'(1);
      end else if (byp_dec) begin
        nodes_r[wr_addr].byp <= nodes_r[wr_addr].byp - BYP_W'(1);
      end
    end
  end

  // combinational read ports
  always_comb begin
    if (eval_in_range_s) eval_node = nodes_r[eval_addr];
    else                 eval_node = '0;
    if (insp_in_range_s) insp_node = nodes_r[insp_addr];
    else                 insp_node = '0;
  end

endmodule

// File: rtl/cgra_xy_router_chk.sv
// Protocol and bound checks for cgra_xy_router; no functional logic.
module cgra_xy_router_chk #(
  parameter int SD = 6,
  parameter int HW = 3
) (
  input logic          clk,
  input logic          reset,
  input logic          push,
  input logic [HW-1:0] sp,
  input logic          res_valid,
  input logic          res_ready,
  input logic          res_ok,
  input logic [HW-1:0] res_hops
);

  a_stack_bound: assert property (@(posedge clk) disable iff (reset)
    push |-> (int'(sp) < SD));

  a_resp_hold: assert property (@(posedge clk) disable iff (reset)
    (res_valid && !res_ready) |=> (res_valid && $stable(res_ok) && $stable(res_hops)));

endmodule

// File: rtl/cgra_xy_router.sv
// Greedy XY edge router over a GRID_W x GRID_H mesh with rip-up of failed partial paths.
module cgra_xy_router
  import cgra_route_pkg::*;
#(
  parameter int GRID_W     = 4,
  parameter int GRID_H     = 4,
  parameter int MAX_BYPASS = 2,
  parameter int NODES      = GRID_W * GRID_H,
  parameter int AW         = $clog2(NODES),
  parameter int SD         = GRID_W + GRID_H - 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clr_start,
  output logic                            busy,
  input  logic                            edge_valid,
  output logic                            edge_ready,
  input  logic [AW-1:0]                   edge_src,
  input  logic [AW-1:0]                   edge_dst,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic                            res_ok,
  output logic [$clog2(SD+1)-1:0]         res_hops,
  input  logic [AW-1:0]                   rd_addr,
  output logic [3:0]                      rd_links,
  output logic [$clog2(MAX_BYPASS+1)-1:0] rd_byp
);

  localparam int HW = $clog2(SD + 1);
  localparam int BW = $clog2(MAX_BYPASS + 1);

  state_e        state_r;
  logic [AW-1:0] src_r, dst_r, cur_r;
  logic          first_r;
  logic [HW-1:0] sp_r;
  stack_entry_t  stack_r [SD];
  logic          res_valid_r, res_ok_r;
  logic [HW-1:0] res_hops_r;

  node_t         cur_node_s, insp_node_s;
  int            cur_x_s, cur_y_s, dst_x_s, dst_y_s;
  dir_e          h_dir_s, v_dir_s, move_dir_s;
  logic          move_ok_s, at_dst_s, out_of_range_s, push_s;
  stack_entry_t  top_s;
  logic          tbl_wr_en_s, tbl_wr_set_s, tbl_inc_s, tbl_dec_s, tbl_clr_s;
  logic [AW-1:0] tbl_wr_addr_s;
  dir_e          tbl_wr_dir_s;

  function automatic logic legal(input node_t n, input dir_e d, input logic first);
    return (n.links[d] == 1'b0) && (first || (int'(n.byp) < MAX_BYPASS));
  endfunction

  // next-hop selection: horizontal first, vertical as fallback
  always_comb begin
    cur_x_s    = idx2x(int'(cur_r), GRID_W);
    cur_y_s    = idx2y(int'(cur_r), GRID_W);
    dst_x_s    = idx2x(int'(dst_r), GRID_W);
    dst_y_s    = idx2y(int'(dst_r), GRID_W);
    h_dir_s    = (dst_x_s > cur_x_s) ? DIR_RIGHT : DIR_LEFT;
    v_dir_s    = (dst_y_s > cur_y_s) ? DIR_BOT : DIR_TOP;
    move_ok_s  = 1'b0;
    move_dir_s = DIR_BOT;
    if ((dst_x_s != cur_x_s) && legal(cur_node_s, h_dir_s, first_r)) begin
      move_ok_s  = 1'b1;
      move_dir_s = h_dir_s;
    end else if ((dst_y_s != cur_y_s) && legal(cur_node_s, v_dir_s, first_r)) begin
      move_ok_s  = 1'b1;
      move_dir_s = v_dir_s;
    end else begin
      move_ok_s  = 1'b0;
    end
    at_dst_s       = (cur_r == dst_r);
    out_of_range_s = ({1'b0, src_r} >= (AW+1)'(NODES)) || ({1'b0, dst_r} >= (AW+1)'(NODES));
    push_s         = (state_r == S_EVAL) && !at_dst_s && move_ok_s;
    top_s          = (sp_r == '0) ? stack_r[0] : stack_r[sp_r - HW'(1)];
  end

  // table write-port decode; slot 0 is the source PE, which never counted a bypass
  always_comb begin
    tbl_wr_en_s   = 1'b0;
    tbl_wr_addr_s = cur_r;
    tbl_wr_dir_s  = move_dir_s;
    tbl_wr_set_s  = 1'b1;
    tbl_inc_s     = 1'b0;
    tbl_dec_s     = 1'b0;
    tbl_clr_s     = (state_r == S_CLEAR);
    case (state_r)
      S_EVAL: begin
        if (push_s) begin
          tbl_wr_en_s = 1'b1;
          tbl_inc_s   = !first_r;
        end else begin
          tbl_wr_en_s = 1'b0;
        end
      end
      S_UNWIND: begin
        if (sp_r != '0) begin
          tbl_wr_en_s   = 1'b1;
          tbl_wr_addr_s = top_s.node[AW-1:0];
          tbl_wr_dir_s  = top_s.dir;
          tbl_wr_set_s  = 1'b0;
          tbl_dec_s     = (sp_r != HW'(1));
        end else begin
          tbl_wr_en_s = 1'b0;
        end
      end
      default: tbl_wr_en_s = 1'b0;
    endcase
  end

  cgra_node_table #(.NODES(NODES), .AW(AW)) u_table (
    .clk       (clk),
    .reset     (reset),
    .clr_all   (tbl_clr_s),
    .wr_en     (tbl_wr_en_s),
    .wr_addr   (tbl_wr_addr_s),
    .wr_dir    (tbl_wr_dir_s),
    .wr_set    (tbl_wr_set_s),
    .byp_inc   (tbl_inc_s),
    .byp_dec   (tbl_dec_s),
    .eval_addr (cur_r),
    .eval_node (cur_node_s),
    .insp_addr (rd_addr),
    .insp_node (insp_node_s)
  );

  // routing FSM with registered result stream
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      src_r       <= '0;
      dst_r       <= '0;
      cur_r       <= '0;
      first_r     <= 1'b0;
      sp_r        <= '0;
      res_valid_r <= 1'b0;
      res_ok_r    <= 1'b0;
      res_hops_r  <= '0;
      for (int i = 0; i < SD; i++) stack_r[i] <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (clr_start) begin
            state_r <= S_CLEAR;
          end else if (edge_valid) begin
            src_r   <= edge_src;
            dst_r   <= edge_dst;
            cur_r   <= edge_src;
            first_r <= 1'b1;
            sp_r    <= '0;
            state_r <= S_CHECK;
          end
        end
        S_CLEAR: state_r <= S_IDLE;
        S_CHECK: begin
          if (out_of_range_s) begin
            res_ok_r    <= 1'b0;
            res_hops_r  <= '0;
            res_valid_r <= 1'b1;
            state_r     <= S_RESP;
          end else begin
            state_r <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (at_dst_s) begin
            res_ok_r    <= 1'b1;
            res_hops_r  <= sp_r;
            res_valid_r <= 1'b1;
            state_r     <= S_RESP;
          end else if (move_ok_s) begin
            stack_r[sp_r] <= '{node: NODE_W'(cur_r), dir: move_dir_s};
            sp_r          <= sp_r + HW'(1);
            cur_r         <= AW'(neighbour(int'(cur_r), move_dir_s, GRID_W));
            first_r       <= 1'b0;
          end else begin
            state_r <= S_UNWIND;
          end
        end
        S_UNWIND: begin
          if (sp_r == '0) begin
            res_ok_r    <= 1'b0;
            res_hops_r  <= '0;
            res_valid_r <= 1'b1;
            state_r     <= S_RESP;
          end else begin
            sp_r <= sp_r - HW'(1);
          end
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            state_r     <= S_IDLE;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state_r != S_IDLE);
  assign edge_ready = (state_r == S_IDLE);
  assign res_valid  = res_valid_r;
  assign res_ok     = res_ok_r;
  assign res_hops   = res_hops_r;
  assign rd_links   = insp_node_s.links;
  assign rd_byp     = insp_node_s.byp[BW-1:0];

  cgra_xy_router_chk #(.SD(SD), .HW(HW)) u_chk (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .sp        (sp_r),
    .res_valid (res_valid_r),
    .res_ready (res_ready),
    .res_ok    (res_ok_r),
    .res_hops  (res_hops_r)
  );

endmodule

// File: tb/tb_cgra_xy_router.sv
// Self-checking bench: 4x4 router against an integer-array routing model, plus a 3x3 instance.
module tb_cgra_xy_router;

  localparam int W = 4, H = 4, MB = 2, N = 16;

  logic       clk = 1'b0;
  logic       reset, clr_start, edge_valid, res_ready;
  logic [3:0] edge_src, edge_dst, rd_addr;
  logic       busy, edge_ready, res_valid, res_ok;
  logic [2:0] res_hops;
  logic [3:0] rd_links;
  logic [1:0] rd_byp;

  logic       s3_clr_start, s3_edge_valid, s3_res_ready;
  logic [3:0] s3_edge_src, s3_edge_dst, s3_rd_addr;
  logic       s3_busy, s3_edge_ready, s3_res_valid, s3_res_ok;
  logic [2:0] s3_res_hops;
  logic [3:0] s3_rd_links;
  logic [1:0] s3_rd_byp;

  int n_checks = 0, n_errors = 0;
  int mlinks [N][4];
  int mbyp   [N];
  bit r_ok;
  int r_hops, r_lat;

  cgra_xy_router #(.GRID_W(W), .GRID_H(H), .MAX_BYPASS(MB)) dut (
    .clk(clk), .reset(reset), .clr_start(clr_start), .busy(busy),
    .edge_valid(edge_valid), .edge_ready(edge_ready), .edge_src(edge_src), .edge_dst(edge_dst),
    .res_valid(res_valid), .res_ready(res_ready), .res_ok(res_ok), .res_hops(res_hops),
    .rd_addr(rd_addr), .rd_links(rd_links), .rd_byp(rd_byp));

  cgra_xy_router #(.GRID_W(3), .GRID_H(3), .MAX_BYPASS(MB)) dut3 (
    .clk(clk), .reset(reset), .clr_start(s3_clr_start), .busy(s3_busy),
    .edge_valid(s3_edge_valid), .edge_ready(s3_edge_ready), .edge_src(s3_edge_src), .edge_dst(s3_edge_dst),
    .res_valid(s3_res_valid), .res_ready(s3_res_ready), .res_ok(s3_res_ok), .res_hops(s3_res_hops),
    .rd_addr(s3_rd_addr), .rd_links(s3_rd_links), .rd_byp(s3_rd_byp));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // every cycle: ready must be exactly the complement of busy
  always @(negedge clk) begin
    if (!reset) begin
      chk("ready_vs_busy", {31'd0, edge_ready}, {31'd0, !busy});
      chk("ready_vs_busy_3x3", {31'd0, s3_edge_ready}, {31'd0, !s3_busy});
    end
  end

  function automatic void model_clear();
    for (int n = 0; n < N; n++) begin
      mbyp[n] = 0;
      for (int d = 0; d < 4; d++) mlinks[n][d] = 0;
    end
  endfunction

  function automatic bit m_legal(input int n, input int d, input bit first);
    return (mlinks[n][d] == 0) && (first || mbyp[n] < MB);
  endfunction

  // greedy XY at the level of grid coordinates; failing paths are fully ripped up
  function automatic void model_route(input int s, input int d, output bit ok, output int hops, output int lat);
    int sn[$];
    int sd[$];
    int cur, cx, cy, dx, dy, dir, nb, pn, pd;
    bit first, moved;
    cur = s; first = 1'b1; dir = 0; nb = 0;
    ok = 1'b0; hops = 0; lat = -1;
    if (s >= N || d >= N) begin
      lat = 1;
      return;
    end
    for (int guard = 0; guard < 64; guard++) begin
      if (cur == d) begin
        ok = 1'b1; hops = sn.size(); lat = 2 + hops;
        return;
      end
      cx = cur % W; cy = cur / W; dx = d % W; dy = d / W; moved = 1'b0;
      if (dx != cx) begin
        dir = (dx > cx) ? 3 : 2; nb = (dx > cx) ? cur + 1 : cur - 1;
        moved = m_legal(cur, dir, first);
      end
      if (!moved && dy != cy) begin
        dir = (dy > cy) ? 0 : 1; nb = (dy > cy) ? cur + W : cur - W;
        moved = m_legal(cur, dir, first);
      end
      if (moved) begin
        mlinks[cur][dir] = 1;
        if (!first) mbyp[cur]++;
        sn.push_back(cur); sd.push_back(dir);
        cur = nb; first = 1'b0;
      end else begin
        lat = 2 + sn.size() + sn.size() + 1;
        while (sn.size() > 0) begin
          pn = sn.pop_back(); pd = sd.pop_back();
          mlinks[pn][pd] = 0;
          if (sn.size() > 0) mbyp[pn]--;
        end
        return;
      end
    end
  endfunction

  task automatic peek(input int node, input int exp_links, input int exp_byp, input string name);
    rd_addr = node[3:0];
    #1;
    chk({name, "_links"}, {28'd0, rd_links}, exp_links);
    chk({name, "_byp"}, {30'd0, rd_byp}, exp_byp);
  endtask

  task automatic check_table(input string name);
    int e;
    for (int n = 0; n < N; n++) begin
      e = mlinks[n][3] * 8 + mlinks[n][2] * 4 + mlinks[n][1] * 2 + mlinks[n][0];
      peek(n, e, mbyp[n], name);
    end
    @(posedge clk); #1;
  endtask

  // one edge on the 4x4 instance; result held for 'hold' cycles with ignored pulses
  task automatic run_edge(input int s, input int d, input int hold);
    int lat;
    model_route(s, d, r_ok, r_hops, r_lat);
    edge_src = s[3:0]; edge_dst = d[3:0]; edge_valid = 1'b1;
    @(posedge clk); #1;
    edge_valid = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("res_valid_seen", {31'd0, res_valid}, 32'd1);
    chk("latency", lat, r_lat);
    chk("res_ok", {31'd0, res_ok}, {31'd0, r_ok});
    chk("res_hops", {29'd0, res_hops}, r_hops);
    for (int i = 0; i < hold; i++) begin
      edge_valid = i[0]; clr_start = !i[0]; edge_src = 4'd2; edge_dst = 4'd14;
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_ok", {31'd0, res_ok}, {31'd0, r_ok});
      chk("hold_hops", {29'd0, res_hops}, r_hops);
      chk("hold_ready", {31'd0, edge_ready}, 32'd0);
    end
    edge_valid = 1'b0; clr_start = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("valid_drop", {31'd0, res_valid}, 32'd0);
    chk("idle_after_resp", {31'd0, edge_ready}, 32'd1);
  endtask

  task automatic run3(input int s, input int d, input int eok, input int ehops, input int elat);
    int lat;
    s3_edge_src = s[3:0]; s3_edge_dst = d[3:0]; s3_edge_valid = 1'b1;
    @(posedge clk); #1;
    s3_edge_valid = 1'b0;
    lat = 0;
    while (!s3_res_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("g3_latency", lat, elat);
    chk("g3_ok", {31'd0, s3_res_ok}, eok);
    chk("g3_hops", {29'd0, s3_res_hops}, ehops);
    s3_res_ready = 1'b1;
    @(posedge clk); #1;
    s3_res_ready = 1'b0;
    chk("g3_valid_drop", {31'd0, s3_res_valid}, 32'd0);
  endtask

  task automatic do_clear();
    clr_start = 1'b1; edge_valid = 1'b1; edge_src = 4'd0; edge_dst = 4'd15;
    @(posedge clk); #1;
    clr_start = 1'b0; edge_valid = 1'b0;
    chk("clear_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("clear_done", {31'd0, busy}, 32'd0);
    chk("clear_no_result", {31'd0, res_valid}, 32'd0);
    model_clear();
  endtask

  initial begin
    reset = 1'b1; clr_start = 1'b0; edge_valid = 1'b0; res_ready = 1'b0;
    edge_src = '0; edge_dst = '0; rd_addr = '0;
    s3_clr_start = 1'b0; s3_edge_valid = 1'b0; s3_res_ready = 1'b0;
    s3_edge_src = '0; s3_edge_dst = '0; s3_rd_addr = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_ok", {31'd0, res_ok}, 32'd0);
    chk("rst_res_hops", {29'd0, res_hops}, 32'd0);
    chk("rst_edge_ready", {31'd0, edge_ready}, 32'd1);
    check_table("rst_tbl");

    run_edge(0, 5, 0);
    chk("pin_e1", {r_ok, 7'd0, r_hops[7:0], r_lat[7:0]}, {1'b1, 7'd0, 8'd2, 8'd4});
    peek(0, 8, 0, "e1_n0"); peek(1, 1, 1, "e1_n1");
    check_table("e1_tbl");

    run_edge(0, 5, 0);
    chk("pin_e2", {r_ok, 7'd0, r_hops[7:0]}, {1'b1, 7'd0, 8'd2});
    peek(0, 9, 0, "e2_n0"); peek(4, 8, 1, "e2_n4");
    check_table("e2_tbl");

    run_edge(0, 5, 0);
    chk("pin_e3", {r_ok, 7'd0, r_hops[7:0], r_lat[7:0]}, {1'b0, 7'd0, 8'd0, 8'd3});
    check_table("e3_tbl");

    do_clear();
    check_table("clr_tbl");
    run_edge(0, 5, 0);
    peek(0, 8, 0, "c1_n0"); peek(1, 1, 1, "c1_n1");
    check_table("c1_tbl");

    do_clear();
    run_edge(4, 6, 0);
    peek(5, 8, 1, "b1_n5");
    run_edge(1, 9, 0);
    peek(5, 9, 2, "b2_n5");
    run_edge(6, 4, 0);
    chk("pin_byp_fail", {r_ok, 7'd0, r_lat[7:0]}, {1'b0, 7'd0, 8'd5});
    peek(6, 0, 0, "b3_n6"); peek(5, 9, 2, "b3_n5");
    check_table("byp_tbl");

    run_edge(2, 15, 5);
    check_table("bp_tbl");
    run_edge(10, 10, 0);
    chk("pin_self", {r_ok, 7'd0, r_hops[7:0], r_lat[7:0]}, {1'b1, 7'd0, 8'd0, 8'd2});
    check_table("self_tbl");

    run3(9, 0, 0, 0, 1);
    run3(0, 8, 1, 4, 6);
    s3_rd_addr = 4'd0; #1;
    chk("g3_n0_links", {28'd0, s3_rd_links}, 32'd8);
    s3_rd_addr = 4'd2; #1;
    chk("g3_n2_links", {28'd0, s3_rd_links}, 32'd1);
    chk("g3_n2_byp", {30'd0, s3_rd_byp}, 32'd1);
    @(posedge clk); #1;

    edge_src = 4'd0; edge_dst = 4'd15; edge_valid = 1'b1;
    @(posedge clk); #1;
    edge_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_eval_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_ready", {31'd0, edge_ready}, 32'd1);
    chk("mid_rst_valid", {31'd0, res_valid}, 32'd0);
    model_clear();
    check_table("mid_rst_tbl");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
